instruction_fetch: RTL and testbench

Initiator side of the instruction-memory read interface. Owns the program counter, drives the 14-bit fetch address into the combinational 16K x 19-bit instruction memory, and captures each returned word into a 2-entry buffer. Presents {pc, instruction} to decode over a valid/ready handshake. Supports a one-cycle branch/jump redirect that flushes buffered instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instruction_fetch_if.sv | 42 ++++
 rtl/instruction_fetch_buffer.sv | 70 +++++++
 rtl/instruction_fetch.sv | 80 ++++++++
 tb/tb_instruction_fetch.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared constants and types for the instruction fetch slice.
//   ADDR_W   : fetch address / PC width (16K-word instruction memory)
//   INSTR_W  : instruction word width
//   RESET_PC : PC loaded while reset is asserted
//   fetch_entry_t : one buffered fetch result {pc, instr}
package fetch_pkg;
    localparam int ADDR_W  = 14;
    localparam int INSTR_W = 19;

    localparam logic [ADDR_W-1:0] RESET_PC = 14'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Bundles the instruction-memory port, the redirect request, the decode
//   valid/ready handshake and the stall counter output of the fetch unit.
//   modport master : the fetch unit (drives imem_addr and the out_* head)
//   modport slave  : the surroundings (memory, branch unit, decode)
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [15:0]        stall_cycles;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output stall_cycles
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  stall_cycles
    );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer
//   Two-entry synchronous FIFO of fetch_entry_t. Entry 0 is always the head,
//   so the head output is a plain register with no read mux.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     i_push       : write i_push_data at the tail (ignored when full
//                    unless a pop happens in the same cycle)
//     i_pop        : drop the head entry
//     i_flush      : empty the FIFO; wins over push and pop
//     o_count      : number of valid entries, 0..2
//     o_head       : head entry (stale when o_count == 0)
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);
    fetch_entry_t r_head;
    fetch_entry_t r_tail;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count != 2'd2) begin
                        if (r_count == 2'd0) r_head <= i_push_data;
                        else                 r_tail <= i_push_data;
                        r_count <= r_count + 2'd1;
                    end
                end
                2'b01: begin
                    if (r_count != 2'd0) begin
                        r_head  <= r_tail;
                        r_count <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    // Count is unchanged; new word lands behind whatever
                    // survives the pop, preserving order.
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end else begin
                        r_head  <= i_push_data;
                        r_count <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Initiator side of the instruction-memory read path. Holds the PC,
//   drives it straight onto imem_addr, captures {pc, imem_instr} into a
//   two-entry buffer and presents the head to decode over valid/ready.
//   A redirect loads a new PC and flushes the buffer in one cycle.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : instruction_fetch_if.master (imem, redirect, decode
//                  handshake, stall_cycles)
//   Build option:
//     IFETCH_STALL_CNT_EN : when defined, stall_cycles counts cycles with
//                           out_valid=1 and out_ready=0, saturating at
//                           16'hFFFF; otherwise it is tied to zero.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P_RESET_PC = RESET_PC
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;
    logic              w_valid;
    logic              w_pop;
    logic              w_fetch;

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid & bus.out_ready;
    // A pop frees a slot in the same edge, so a full buffer still fetches.
    assign w_fetch = ~bus.redirect_valid & ((w_count != 2'd2) | w_pop);

    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = bus.imem_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= P_RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
        end else if (w_fetch) begin
            r_pc <= r_pc + 1'b1;   // wraps at 2^ADDR_W
        end
    end

    fetch_buffer u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fetch),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;

`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_valid & ~bus.out_ready & (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cnt;
`else
    assign bus.stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import fetch_pkg::*;

`ifdef IFETCH_STALL_CNT_EN
    localparam int STALL_ON = 1;
`else
    localparam int STALL_ON = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   n_fail;

    instruction_fetch_if ifc ();

    instruction_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    // Memory image: arbitrary but distinct per address.
    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [4:0] lo;
        lo = a[4:0] + 5'd7;
        return {a ^ 14'h15A3, lo};
    endfunction

    assign ifc.imem_instr = mem_word(ifc.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [ADDR_W-1:0] pc);
        chk({tag, " valid"}, 32'(ifc.out_valid), 32'd1);
        chk({tag, " pc"},    32'(ifc.out_pc),    32'(pc));
        chk({tag, " instr"}, 32'(ifc.out_instr), 32'(mem_word(pc)));
    endtask

    initial begin
        logic [ADDR_W-1:0] wrap_exp [4];
        wrap_exp = '{14'd16382, 14'd16383, 14'd0, 14'd1};
        n_pass = 0; n_total = 0; n_fail = 0;
        rst_n = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst imem_addr", 32'(ifc.imem_addr), 32'(RESET_PC));
        chk("rst out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst out_instr", 32'(ifc.out_instr), 32'd0);
        chk("rst out_pc",    32'(ifc.out_pc),    32'd0);
        chk("rst stall",     32'(ifc.stall_cycles), 32'd0);

        // Reset release, streaming 0..4
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_head($sformatf("stream%0d", i), 14'(i));
        end

        // Backpressure with head pc=5
        @(negedge clk);
        chk_head("bp head", 14'd5);
        ifc.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_head($sformatf("bp hold%0d", k), 14'd5);
            chk($sformatf("bp imem_addr%0d", k), 32'(ifc.imem_addr), 32'd7);
        end
        chk("bp stall", 32'(ifc.stall_cycles), 32'(6 * STALL_ON));
        ifc.out_ready = 1'b1;
        for (int i = 6; i < 9; i++) begin
            @(negedge clk);
            chk_head($sformatf("bp release%0d", i), 14'(i));
        end

        // Redirect while full (entries 8,9 buffered, no pop)
        ifc.out_ready = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 14'd100;
        @(negedge clk);
        chk("rdfull out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rdfull imem_addr", 32'(ifc.imem_addr), 32'd100);
        ifc.redirect_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk_head("rdfull first", 14'd100);
        @(negedge clk);
        chk_head("rdfull second", 14'd101);
        chk("rdfull stall", 32'(ifc.stall_cycles), 32'(7 * STALL_ON));

        // Redirect with simultaneous pop of pc 7
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 14'd7;
        @(negedge clk);
        chk("rd7 out_valid", 32'(ifc.out_valid), 32'd0);
        ifc.redirect_valid = 1'b0;
        @(negedge clk);
        chk_head("rd7 head", 14'd7);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 14'd200;
        @(negedge clk);
        chk("rdpop out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rdpop imem_addr", 32'(ifc.imem_addr), 32'd200);
        ifc.redirect_valid = 1'b0;
        @(negedge clk);
        chk_head("rdpop next", 14'd200);

        // PC wrap
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 14'd16382;
        @(negedge clk);
        chk("wrap out_valid", 32'(ifc.out_valid), 32'd0);
        ifc.redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_head($sformatf("wrap%0d", i), wrap_exp[i]);
        end

        // Async reset mid-stream with a full buffer
        ifc.out_ready = 1'b0;
        @(negedge clk);
        chk_head("arst pre", 14'd1);
        chk("arst pre stall", 32'(ifc.stall_cycles), 32'(8 * STALL_ON));
        #3 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(ifc.out_valid), 32'd0);
        chk("arst imem_addr", 32'(ifc.imem_addr), 32'd0);
        chk("arst out_pc",    32'(ifc.out_pc),    32'd0);
        chk("arst out_instr", 32'(ifc.out_instr), 32'd0);
        chk("arst stall",     32'(ifc.stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk_head("restart0", 14'd0);
        @(negedge clk);
        chk_head("restart1", 14'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
